// File: rtl/risky_pkg.sv
// risky_pkg: shared RV32I opcodes, funct3 codes, ALU/immediate enums and ALU helpers
package risky_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;

  // instr[30] selects SUB only for register-register ops; OP-IMM uses it for SRAI alone
  function automatic alu_op_t decode_alu(input logic [2:0] f3, input logic alt, input logic is_reg);
    case (f3)
      F3_ADD:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction
endpackage

// File: rtl/risky_memory.sv
// risky_memory: unified word memory, combinational fetch/load reads, byte-enabled clocked write
module risky_memory #(
  parameter int MEM_WORDS = 4096
) (
  input  logic        clock,
  input  logic [29:0] fetch_addr,
  output logic [31:0] instr,
  input  logic [29:0] data_addr,
  output logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [3:0]  be
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  logic [31:0] ram [0:MEM_WORDS-1];
  logic [AW-1:0] fidx, didx;

  assign fidx = AW'(fetch_addr % 30'(MEM_WORDS));
  assign didx = AW'(data_addr % 30'(MEM_WORDS));
  assign instr = ram[fidx];
  assign rdata = ram[didx];

  always_ff @(posedge clock)
    for (int i = 0; i < 4; i++)
      if (be[i]) ram[didx][8*i +: 8] <= wdata[8*i +: 8];
endmodule

// File: rtl/risky_regfile.sv
// risky_regfile: 32x32 register file, two combinational reads, one clocked write, x0 hardwired to zero
module risky_regfile (
  input  logic        clock,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] reg_file [0:31];

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : reg_file[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : reg_file[ra2];

  always_ff @(posedge clock)
    if (we && wa != 5'd0) reg_file[wa] <= wd;
endmodule

// File: rtl/risky_core_top.sv
// risky_core_top: single-cycle RV32I core; one instruction retires per clock edge
module risky_core_top
  import risky_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] wb_data
);
  logic [31:0] pc, instr, imm, rs1_data, rs2_data, alu_b, alu_res;
  logic [31:0] mem_rdata, load_data, store_data, wb_val, next_pc, pc_plus4, pc_imm;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [3:0]  be;
  logic        writes_rd, take, is_reg, is_jump;
  imm_t        imm_sel;
  alu_op_t     alu_op;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign is_reg = opcode == OP_REG;
  assign is_jump = opcode == OP_JAL || opcode == OP_JALR;

  assign imm_sel = (opcode == OP_STORE)  ? IMM_S :
                   (opcode == OP_BRANCH) ? IMM_B :
                   (opcode == OP_LUI || opcode == OP_AUIPC) ? IMM_U :
                   (opcode == OP_JAL)    ? IMM_J : IMM_I;

  assign imm = (imm_sel == IMM_S) ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
               (imm_sel == IMM_B) ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
               (imm_sel == IMM_U) ? {instr[31:12], 12'd0} :
               (imm_sel == IMM_J) ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
                                    {{20{instr[31]}}, instr[31:20]};

  // Loads, stores and JALR reuse the adder for rs1+imm
  assign alu_op  = (is_reg || opcode == OP_IMM) ? decode_alu(f3, instr[30], is_reg) : ALU_ADD;
  assign alu_b   = is_reg ? rs2_data : imm;
  assign alu_res = alu(alu_op, rs1_data, alu_b);

  assign take = (f3 == F3_BEQ)  ? rs1_data == rs2_data :
                (f3 == F3_BNE)  ? rs1_data != rs2_data :
                (f3 == F3_BLT)  ? $signed(rs1_data) <  $signed(rs2_data) :
                (f3 == F3_BGE)  ? $signed(rs1_data) >= $signed(rs2_data) :
                (f3 == F3_BLTU) ? rs1_data <  rs2_data :
                (f3 == F3_BGEU) ? rs1_data >= rs2_data : 1'b0;

  assign store_data = (f3 == F3_B) ? {4{rs2_data[7:0]}} :
                      (f3 == F3_H) ? {2{rs2_data[15:0]}} : rs2_data;
  assign be = !(reset && opcode == OP_STORE) ? 4'b0000 :
              (f3 == F3_B) ? 4'b0001 << alu_res[1:0] :
              (f3 == F3_H) ? (alu_res[1] ? 4'b1100 : 4'b0011) : 4'b1111;

  assign ld_byte   = mem_rdata[{alu_res[1:0], 3'b000} +: 8];
  assign ld_half   = alu_res[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign load_data = (f3 == F3_B)  ? {{24{ld_byte[7]}}, ld_byte} :
                     (f3 == F3_H)  ? {{16{ld_half[15]}}, ld_half} :
                     (f3 == F3_BU) ? {24'd0, ld_byte} :
                     (f3 == F3_HU) ? {16'd0, ld_half} : mem_rdata;

  assign pc_plus4 = pc + 32'd4;
  assign pc_imm   = pc + imm;

  assign writes_rd = opcode == OP_LUI || opcode == OP_AUIPC || is_jump ||
                     opcode == OP_LOAD || opcode == OP_IMM || is_reg;
  assign wb_val = (opcode == OP_LUI)   ? imm :
                  (opcode == OP_AUIPC) ? pc_imm :
                  is_jump              ? pc_plus4 :
                  (opcode == OP_LOAD)  ? load_data :
                  (opcode == OP_IMM || is_reg) ? alu_res : 32'd0;
  assign wb_data = reset ? wb_val : 32'd0;

  assign next_pc = (opcode == OP_JAL || (opcode == OP_BRANCH && take)) ? pc_imm :
                   (opcode == OP_JALR) ? {alu_res[31:1], 1'b0} : pc_plus4;

  always_ff @(posedge clock or negedge reset)
    if (!reset) pc <= RESET_PC;
    else pc <= next_pc;

  risky_regfile regFile_inst (
    .clock(clock),
    .we(reset && writes_rd),
    .ra1(rs1),
    .ra2(rs2),
    .wa(rd),
    .wd(wb_val),
    .rd1(rs1_data),
    .rd2(rs2_data)
  );

  risky_memory #(.MEM_WORDS(MEM_WORDS)) main_memory (
    .clock(clock),
    .fetch_addr(pc[31:2]),
    .instr(instr),
    .data_addr(alu_res[31:2]),
    .rdata(mem_rdata),
    .wdata(store_data),
    .be(be)
  );
endmodule

// File: tb/tb_risky_core_top.sv
// tb_risky_core_top: directed programs with hand-computed writeback, register and memory results
module tb_risky_core_top;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] wb_data;
  int          tests = 0;
  int          failed = 0;
  logic [31:0] prog [$];
  logic [31:0] exp_wb [$];
  logic [31:0] exp_pc [$];

  risky_core_top dut (.clock(clock), .reset(reset), .wb_data(wb_data));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    logic [31:0] m;
    m = imm;
    return {m[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] m;
    m = imm;
    return {m[11:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] m;
    m = imm;
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(input int imm, input int rd, input int op);
    logic [31:0] m;
    m = imm;
    return {m[19:0], 5'(rd), 7'(op)};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] m;
    m = imm;
    return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6f};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 0, rd, 'h13);
  endfunction

  // Hold reset, clear state, load prog, wait two cycles; caller releases reset
  task automatic load();
    reset = 1'b0;
    for (int i = 0; i < 4096; i++) dut.main_memory.ram[i] = 32'h0;
    for (int i = 0; i < 32; i++) dut.regFile_inst.reg_file[i] = 32'h0;
    foreach (prog[i]) dut.main_memory.ram[i] = prog[i];
    repeat (2) @(negedge clock);
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run_table(input string name);
    foreach (exp_wb[k]) begin
      if (exp_pc.size() > 0) chk($sformatf("%s_pc%0d", name, k), dut.pc, exp_pc[k]);
      chk($sformatf("%s_wb%0d", name, k), wb_data, exp_wb[k]);
      step();
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("rst_pc", dut.pc, 32'h0);
    chk("rst_wb", wb_data, 32'h0);

    prog = '{addi(1,0,0), addi(2,0,1), addi(3,0,8), enc_b(24,0,3,0), enc_r(0,2,1,0,4),
             addi(1,2,0), addi(2,4,0), addi(3,3,-1), enc_j(-20,0), addi(9,1,0), enc_j(0,0)};
    load();
    reset = 1'b1;
    repeat (1600) @(posedge clock);
    @(negedge clock);
    chk("fib_x9", dut.regFile_inst.reg_file[9], 32'h15);
    chk("fib_halt_pc", dut.pc, 32'd40);
    chk("fib_halt_wb", wb_data, 32'd44);

    prog = '{addi(1,0,48), addi(2,0,64), enc_b(24,2,1,0), enc_b(12,2,1,4), enc_r(32,2,1,0,1),
             enc_j(-12,0), enc_r(32,1,2,0,2), enc_j(-20,0), addi(9,1,0), enc_j(0,0)};
    load();
    reset = 1'b1;
    repeat (1600) @(posedge clock);
    @(negedge clock);
    chk("gcd_x9", dut.regFile_inst.reg_file[9], 32'h10);
    chk("gcd_x2", dut.regFile_inst.reg_file[2], 32'h10);

    prog = '{addi(0,0,5), addi(1,0,-1), enc_j(0,0)};
    load();
    reset = 1'b1;
    #1;
    chk("x0_wb", wb_data, 32'd5);
    step();
    chk("x0_kept", dut.regFile_inst.reg_file[0], 32'h0);
    chk("x1_wb", wb_data, 32'hFFFF_FFFF);
    step();
    chk("x1_val", dut.regFile_inst.reg_file[1], 32'hFFFF_FFFF);

    prog = '{enc_u('h80008,1,'h37), addi(1,1,'hFF), enc_s('h100,1,0,2),
             enc_i('h100,0,0,2,3), enc_i('h100,0,4,3,3), enc_i('h100,0,1,4,3), enc_i('h100,0,5,5,3),
             enc_i('h103,0,0,6,3), enc_i('h102,0,5,7,3), enc_s('h101,1,0,0), enc_i('h100,0,2,8,3),
             enc_s('h102,1,0,1), enc_i('h100,0,2,9,3), enc_j(0,0)};
    exp_wb = '{32'h8000_8000, 32'h8000_80FF, 32'h0, 32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF,
               32'h0000_80FF, 32'hFFFF_FF80, 32'h0000_8000, 32'h0, 32'h8000_FFFF, 32'h0,
               32'h80FF_FFFF, 32'd56};
    exp_pc = {};
    load();
    reset = 1'b1;
    #1;
    run_table("mem");
    chk("mem_ram", dut.main_memory.ram[64], 32'h80FF_FFFF);
    chk("mem_lb_x2", dut.regFile_inst.reg_file[2], 32'hFFFF_FFFF);
    chk("mem_lhu_x5", dut.regFile_inst.reg_file[5], 32'h0000_80FF);
    chk("mem_sb_x8", dut.regFile_inst.reg_file[8], 32'h8000_FFFF);

    prog = '{addi(1,0,-1), addi(2,0,1), enc_b(8,2,1,4), addi(10,0,1), enc_b(8,2,1,6), addi(11,0,2),
             enc_j(8,12), addi(13,0,3), enc_i(41,0,0,14,'h67), addi(15,0,4), enc_u(1,16,'h17), enc_j(0,0)};
    exp_pc = '{32'd0, 32'd4, 32'd8, 32'd16, 32'd20, 32'd24, 32'd32, 32'd40, 32'd44};
    exp_wb = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd2, 32'd28, 32'd36, 32'h1028, 32'd48};
    load();
    reset = 1'b1;
    #1;
    run_table("br");
    chk("br_x10", dut.regFile_inst.reg_file[10], 32'd0);
    chk("br_x11", dut.regFile_inst.reg_file[11], 32'd2);
    chk("br_x12", dut.regFile_inst.reg_file[12], 32'd28);
    chk("br_x13", dut.regFile_inst.reg_file[13], 32'd0);
    chk("br_x14", dut.regFile_inst.reg_file[14], 32'd36);
    chk("br_x16", dut.regFile_inst.reg_file[16], 32'h1028);

    prog = '{enc_r(32,2,1,5,4), enc_r(0,2,1,5,5), enc_r(0,2,3,1,6), enc_r(0,3,1,2,7), enc_r(0,3,1,3,8),
             enc_r(0,3,1,4,9), enc_r(0,2,3,6,10), enc_r(0,2,3,7,11), enc_i('h404,1,5,12,'h13),
             enc_i(31,3,1,13,'h13), enc_i(-1,3,3,14,'h13), enc_i(-1,3,4,15,'h13), enc_r(32,2,3,0,16),
             enc_i(31,1,5,17,'h13), enc_i(0,1,2,18,'h13), enc_i('h10,3,6,19,'h13), enc_r(0,1,1,0,20),
             32'h0000_0073, enc_j(0,0)};
    exp_wb = '{32'hC000_0000, 32'h4000_0000, 32'hA, 32'd1, 32'd0, 32'h8000_0005, 32'h25, 32'd1,
               32'hF800_0000, 32'h8000_0000, 32'd1, 32'hFFFF_FFFA, 32'hFFFF_FFE4, 32'd1, 32'd1,
               32'h15, 32'd0, 32'd0, 32'd76};
    exp_pc = {};
    load();
    dut.regFile_inst.reg_file[1] = 32'h8000_0000;
    dut.regFile_inst.reg_file[2] = 32'd33;
    dut.regFile_inst.reg_file[3] = 32'd5;
    reset = 1'b1;
    #1;
    run_table("alu");
    chk("alu_x4", dut.regFile_inst.reg_file[4], 32'hC000_0000);
    chk("alu_x16", dut.regFile_inst.reg_file[16], 32'hFFFF_FFE4);

    prog = '{addi(1,0,7), addi(2,0,9), addi(3,0,11), enc_j(0,0)};
    load();
    dut.regFile_inst.reg_file[3] = 32'hDEAD;
    reset = 1'b1;
    #1;
    step();
    step();
    chk("mid_pc_before", dut.pc, 32'd8);
    reset = 1'b0;
    #1;
    chk("mid_pc_async", dut.pc, 32'd0);
    chk("mid_wb", wb_data, 32'd0);
    step();
    chk("mid_x3_kept", dut.regFile_inst.reg_file[3], 32'hDEAD);
    chk("mid_x1_kept", dut.regFile_inst.reg_file[1], 32'd7);
    chk("mid_x2_kept", dut.regFile_inst.reg_file[2], 32'd9);
    chk("mid_pc_held", dut.pc, 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_restart_wb", wb_data, 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
